// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the five-stage MIPS pipeline.
// It captures the decoded instruction, resolves Rw and forwards a same-cycle
// write-back into the operands. It also inserts a load-use bubble and squashes
// the instruction on a taken branch or jump.
module id_ex_pipe_reg #(
  parameter int CTRL_W = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic [31:0]       busA_ID,
  input  logic [31:0]       busB_ID,
  input  logic [31:0]       PC_Addr_ID,
  input  logic [15:0]       imm16_ID,
  input  logic [4:0]        shamt_ID,
  input  logic [5:0]        func_ID,
  input  logic [5:0]        OP_ID,
  input  logic [4:0]        Rs_ID,
  input  logic [4:0]        Rt_ID,
  input  logic [4:0]        Rd_ID,
  input  logic [CTRL_W-1:0] ctrl_ID,
  input  logic [31:0]       busW,
  input  logic [4:0]        Rw_Wr,
  input  logic              RegWr_Wr,
  output logic [31:0]       busA_EX,
  output logic [31:0]       busB_EX,
  output logic [31:0]       PC_Addr_EX,
  output logic [15:0]       imm16_EX,
  output logic [4:0]        shamt_EX,
  output logic [5:0]        func_EX,
  output logic [5:0]        OP_EX,
  output logic [4:0]        Rs_EX,
  output logic [4:0]        Rt_EX,
  output logic [4:0]        Rd_EX,
  output logic [CTRL_W-1:0] ctrl_EX,
  output logic [4:0]        Rw_EX,
  output logic              valid_EX,
  output logic              stall_ID
);

  // Control bundle bit positions used locally
  localparam int B_REGDST   = 2;
  localparam int B_MEMTOREG = 9;
  localparam int B_REGWR    = 10;
  localparam int B_JAL      = 15;

  logic [31:0]       bus_a_reg, bus_b_reg, pc_reg;
  logic [15:0]       imm16_reg;
  logic [4:0]        shamt_reg, rs_reg, rt_reg, rd_reg, rw_reg;
  logic [5:0]        func_reg, op_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic              valid_reg;

  logic              fwd_a, fwd_b, hazard, bubble, load;
  logic [31:0]       bus_a_next, bus_b_next;
  logic [4:0]        rw_next;

  // Write-through bypass from the Wr stage; register 0 is never forwarded
  always_comb begin
    fwd_a      = RegWr_Wr && (Rw_Wr != 5'd0) && (Rw_Wr == Rs_ID);
    fwd_b      = RegWr_Wr && (Rw_Wr != 5'd0) && (Rw_Wr == Rt_ID);
    bus_a_next = fwd_a ? busW : busA_ID;
    bus_b_next = fwd_b ? busW : busB_ID;
  end

  // Destination register: Jal links to r31, R-type writes Rd, others write Rt
  always_comb begin
    rw_next = Rt_ID;
    if (ctrl_ID[B_JAL])
      rw_next = 5'd31;
    else if (ctrl_ID[B_REGDST])
      rw_next = Rd_ID;
  end

  // Load-use detection against the load now in EX, plus update selection
  always_comb begin
    hazard = valid_reg && ctrl_reg[B_MEMTOREG] && ctrl_reg[B_REGWR] &&
             (rt_reg != 5'd0) && ((rt_reg == Rs_ID) || (rt_reg == Rt_ID));
    // A squashed instruction must not freeze upstream, so flush masks the stall
    stall_ID = hazard && !flush;
    bubble   = flush || (!hold && hazard);
    load     = !flush && !hold && !hazard;
  end

  // Pipeline register: reset/bubble clear everything, hold keeps, else load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_a_reg <= '0; bus_b_reg <= '0; pc_reg   <= '0; imm16_reg <= '0;
      shamt_reg <= '0; func_reg  <= '0; op_reg   <= '0; rs_reg    <= '0;
      rt_reg    <= '0; rd_reg    <= '0; ctrl_reg <= '0; rw_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (bubble) begin
      bus_a_reg <= '0; bus_b_reg <= '0; pc_reg   <= '0; imm16_reg <= '0;
      shamt_reg <= '0; func_reg  <= '0; op_reg   <= '0; rs_reg    <= '0;
      rt_reg    <= '0; rd_reg    <= '0; ctrl_reg <= '0; rw_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      bus_a_reg <= bus_a_next;
      bus_b_reg <= bus_b_next;
      pc_reg    <= PC_Addr_ID;
      imm16_reg <= imm16_ID;
      shamt_reg <= shamt_ID;
      func_reg  <= func_ID;
      op_reg    <= OP_ID;
      rs_reg    <= Rs_ID;
      rt_reg    <= Rt_ID;
      rd_reg    <= Rd_ID;
      ctrl_reg  <= ctrl_ID;
      rw_reg    <= rw_next;
      valid_reg <= 1'b1;
    end
  end

  assign busA_EX    = bus_a_reg;
  assign busB_EX    = bus_b_reg;
  assign PC_Addr_EX = pc_reg;
  assign imm16_EX   = imm16_reg;
  assign shamt_EX   = shamt_reg;
  assign func_EX    = func_reg;
  assign OP_EX      = op_reg;
  assign Rs_EX      = rs_reg;
  assign Rt_EX      = rt_reg;
  assign Rd_EX      = rd_reg;
  assign ctrl_EX    = ctrl_reg;
  assign Rw_EX      = rw_reg;
  assign valid_EX   = valid_reg;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios plus a randomized
// run checked against a behavioural model of the EX slot.
module tb_id_ex_pipe_reg;
  localparam int CW = 21;
  localparam logic [CW-1:0] C_REGDST   = 21'h000004;
  localparam logic [CW-1:0] C_ALUSRC   = 21'h000008;
  localparam logic [CW-1:0] C_MEMTOREG = 21'h000200;
  localparam logic [CW-1:0] C_REGWR    = 21'h000400;
  localparam logic [CW-1:0] C_JAL      = 21'h008000;
  localparam logic [CW-1:0] C_ADD      = C_REGDST | C_REGWR;
  localparam logic [CW-1:0] C_LW       = C_ALUSRC | C_MEMTOREG | C_REGWR;

  logic clk = 1'b0;
  logic rst_n, hold, flush;
  logic [31:0] busA_ID, busB_ID, PC_Addr_ID, busW;
  logic [15:0] imm16_ID;
  logic [4:0]  shamt_ID, Rs_ID, Rt_ID, Rd_ID, Rw_Wr;
  logic [5:0]  func_ID, OP_ID;
  logic [CW-1:0] ctrl_ID;
  logic RegWr_Wr;
  logic [31:0] busA_EX, busB_EX, PC_Addr_EX;
  logic [15:0] imm16_EX;
  logic [4:0]  shamt_EX, Rs_EX, Rt_EX, Rd_EX, Rw_EX;
  logic [5:0]  func_EX, OP_EX;
  logic [CW-1:0] ctrl_EX;
  logic valid_EX, stall_ID;

  typedef struct packed {
    logic [31:0] bus_a, bus_b, pc;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic [5:0]  func, op;
    logic [4:0]  rs, rt, rd;
    logic [CW-1:0] ctrl;
    logic [4:0]  rw;
    logic        valid;
  } ex_t;

  ex_t exp_st;
  ex_t saved;
  int checks = 0;
  int errors = 0;

  id_ex_pipe_reg #(.CTRL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .busA_ID(busA_ID), .busB_ID(busB_ID), .PC_Addr_ID(PC_Addr_ID),
    .imm16_ID(imm16_ID), .shamt_ID(shamt_ID), .func_ID(func_ID), .OP_ID(OP_ID),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rd_ID(Rd_ID), .ctrl_ID(ctrl_ID),
    .busW(busW), .Rw_Wr(Rw_Wr), .RegWr_Wr(RegWr_Wr),
    .busA_EX(busA_EX), .busB_EX(busB_EX), .PC_Addr_EX(PC_Addr_EX),
    .imm16_EX(imm16_EX), .shamt_EX(shamt_EX), .func_EX(func_EX), .OP_EX(OP_EX),
    .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .Rd_EX(Rd_EX), .ctrl_EX(ctrl_EX),
    .Rw_EX(Rw_EX), .valid_EX(valid_EX), .stall_ID(stall_ID)
  );

  always #5 clk = ~clk;

  // Snapshot of the DUT outputs in model layout
  function automatic ex_t dut_st();
    ex_t s;
    s.bus_a = busA_EX; s.bus_b = busB_EX; s.pc = PC_Addr_EX; s.imm = imm16_EX;
    s.shamt = shamt_EX; s.func = func_EX; s.op = OP_EX; s.rs = Rs_EX;
    s.rt = Rt_EX; s.rd = Rd_EX; s.ctrl = ctrl_EX; s.rw = Rw_EX; s.valid = valid_EX;
    return s;
  endfunction

  // A real load sits in EX writing a nonzero Rt that the ID instruction reads
  function automatic logic model_load_use();
    logic is_load;
    logic reads_it;
    is_load  = exp_st.valid && exp_st.ctrl[9] && exp_st.ctrl[10] && (exp_st.rt != 5'd0);
    reads_it = (exp_st.rt == Rs_ID) || (exp_st.rt == Rt_ID);
    return is_load && reads_it;
  endfunction

  function automatic logic model_stall();
    return model_load_use() && !flush;
  endfunction

  // What the EX slot holds after the coming edge, given present inputs
  function automatic ex_t model_next();
    ex_t n;
    n = '0;
    if (flush) n = '0;
    else if (hold) n = exp_st;
    else if (model_load_use()) n = '0;
    else begin
      n.bus_a = (RegWr_Wr && Rw_Wr != 0 && Rw_Wr == Rs_ID) ? busW : busA_ID;
      n.bus_b = (RegWr_Wr && Rw_Wr != 0 && Rw_Wr == Rt_ID) ? busW : busB_ID;
      n.pc = PC_Addr_ID; n.imm = imm16_ID; n.shamt = shamt_ID;
      n.func = func_ID; n.op = OP_ID; n.rs = Rs_ID; n.rt = Rt_ID; n.rd = Rd_ID;
      n.ctrl = ctrl_ID;
      n.rw = ctrl_ID[15] ? 5'd31 : (ctrl_ID[2] ? Rd_ID : Rt_ID);
      n.valid = 1'b1;
    end
    return n;
  endfunction

  task automatic tick();
    ex_t n;
    n = model_next();
    @(posedge clk);
    #1;
    exp_st = n;
  endtask

  task automatic clear_in();
    hold = 0; flush = 0; busA_ID = 0; busB_ID = 0; PC_Addr_ID = 0; imm16_ID = 0;
    shamt_ID = 0; func_ID = 0; OP_ID = 0; Rs_ID = 0; Rt_ID = 0; Rd_ID = 0;
    ctrl_ID = '0; busW = 0; Rw_Wr = 0; RegWr_Wr = 0;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [CW-1:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    Rs_ID = rs; Rt_ID = rt; Rd_ID = rd; ctrl_ID = ctrl; busA_ID = a; busB_ID = b;
    PC_Addr_ID = $urandom; imm16_ID = 16'($urandom); shamt_ID = 5'($urandom);
    func_ID = 6'($urandom); OP_ID = 6'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_in();
    set_id(5'd3, 5'd4, 5'd5, C_LW | C_JAL, 32'h1234, 32'h5678);
    exp_st = '0;
    #2;
    checks++;
    if (dut_st() !== exp_st) begin
      errors++; $display("FAIL reset_async got %h exp %h", dut_st(), exp_st);
    end
    @(posedge clk); #1;
    checks++;
    if (dut_st() !== exp_st || stall_ID !== 1'b0) begin
      errors++; $display("FAIL reset_held got %h stall %b exp %h stall 0", dut_st(), stall_ID, exp_st);
    end
    rst_n = 1'b1;
    clear_in();
    $display("reset: outputs zero while rst_n low");
  endtask

  task automatic test_plain_load();
    set_id(5'd1, 5'd2, 5'd3, C_ADD, 32'h11, 32'h22);
    tick();
    checks++;
    if (busA_EX !== 32'h11 || busB_EX !== 32'h22 || Rw_EX !== 5'd3 || valid_EX !== 1'b1) begin
      errors++; $display("FAIL plain_load got A=%h B=%h Rw=%0d v=%b exp A=11 B=22 Rw=3 v=1",
                         busA_EX, busB_EX, Rw_EX, valid_EX);
    end
    checks++;
    if (dut_st() !== exp_st) begin
      errors++; $display("FAIL plain_load_all got %h exp %h", dut_st(), exp_st);
    end
    ctrl_ID = C_ADD | C_JAL;
    tick();
    checks++;
    if (Rw_EX !== 5'd31 || dut_st() !== exp_st) begin
      errors++; $display("FAIL jal_rw got Rw=%0d exp 31", Rw_EX);
    end
    $display("plain_load: A=%h B=%h Rw=%0d", busA_EX, busB_EX, Rw_EX);
  endtask

  task automatic test_load_use();
    set_id(5'd7, 5'd5, 5'd0, C_LW, 32'h70, 32'h50);
    tick();
    set_id(5'd5, 5'd6, 5'd8, C_ADD, 32'hA, 32'hB);
    #1;
    checks++;
    if (stall_ID !== 1'b1 || model_stall() !== 1'b1) begin
      errors++; $display("FAIL load_use_stall got %b exp 1", stall_ID);
    end
    tick();
    checks++;
    if (valid_EX !== 1'b0 || ctrl_EX !== '0 || stall_ID !== 1'b0) begin
      errors++; $display("FAIL load_use_bubble got v=%b ctrl=%h stall=%b exp v=0 ctrl=0 stall=0",
                         valid_EX, ctrl_EX, stall_ID);
    end
    tick();
    checks++;
    if (valid_EX !== 1'b1 || Rs_EX !== 5'd5 || dut_st() !== exp_st) begin
      errors++; $display("FAIL load_use_release got v=%b Rs=%0d exp v=1 Rs=5", valid_EX, Rs_EX);
    end
    $display("load_use: one bubble then Rs_EX=%0d loaded", Rs_EX);
  endtask

  task automatic test_no_false_stall();
    set_id(5'd2, 5'd0, 5'd0, C_LW, 32'h1, 32'h2);
    tick();
    set_id(5'd0, 5'd0, 5'd4, C_ADD, 32'h3, 32'h4);
    #1;
    checks++;
    if (stall_ID !== 1'b0) begin
      errors++; $display("FAIL no_stall_r0 got %b exp 0", stall_ID);
    end
    tick();
    set_id(5'd2, 5'd5, 5'd0, C_LW, 32'h1, 32'h2);
    tick();
    flush = 1;
    set_id(5'd5, 5'd1, 5'd4, C_ADD, 32'h3, 32'h4);
    tick();
    flush = 0;
    #1;
    checks++;
    if (stall_ID !== 1'b0 || valid_EX !== 1'b0) begin
      errors++; $display("FAIL no_stall_invalid got stall=%b v=%b exp 0 0", stall_ID, valid_EX);
    end
    $display("no_false_stall: stall=%b", stall_ID);
  endtask

  task automatic test_bypass();
    set_id(5'd1, 5'd1, 5'd2, C_ADD, 32'h0, 32'h0);
    RegWr_Wr = 1; Rw_Wr = 5'd1; busW = 32'hDEADBEEF;
    tick();
    checks++;
    if (busA_EX !== 32'hDEADBEEF || busB_EX !== 32'hDEADBEEF || dut_st() !== exp_st) begin
      errors++; $display("FAIL bypass got A=%h B=%h exp DEADBEEF", busA_EX, busB_EX);
    end
    Rw_Wr = 5'd0; Rs_ID = 5'd0; Rt_ID = 5'd0;
    tick();
    checks++;
    if (busA_EX !== 32'h0 || busB_EX !== 32'h0) begin
      errors++; $display("FAIL bypass_r0 got A=%h B=%h exp 0", busA_EX, busB_EX);
    end
    RegWr_Wr = 0; Rw_Wr = 5'd1; Rs_ID = 5'd1; Rt_ID = 5'd1;
    tick();
    checks++;
    if (busA_EX !== 32'h0 || busB_EX !== 32'h0) begin
      errors++; $display("FAIL bypass_nowr got A=%h B=%h exp 0", busA_EX, busB_EX);
    end
    clear_in();
    $display("bypass: forwarded and suppressed cases done");
  endtask

  task automatic test_priority();
    set_id(5'd2, 5'd5, 5'd0, C_LW, 32'h1, 32'h2);
    tick();
    set_id(5'd5, 5'd1, 5'd4, C_ADD, 32'h3, 32'h4);
    flush = 1; hold = 1;
    #1;
    checks++;
    if (stall_ID !== 1'b0) begin
      errors++; $display("FAIL prio_flush_stall got %b exp 0", stall_ID);
    end
    tick();
    checks++;
    if (dut_st() !== ex_t'('0)) begin
      errors++; $display("FAIL prio_flush_bubble got %h exp 0", dut_st());
    end
    flush = 0; hold = 0;
    set_id(5'd2, 5'd5, 5'd0, C_LW, 32'h1, 32'h2);
    tick();
    saved = exp_st;
    set_id(5'd5, 5'd1, 5'd4, C_ADD, 32'h3, 32'h4);
    hold = 1;
    tick();
    checks++;
    if (dut_st() !== saved || stall_ID !== 1'b1) begin
      errors++; $display("FAIL prio_hold_hazard got %h stall=%b exp %h stall=1", dut_st(), stall_ID, saved);
    end
    for (int i = 0; i < 3; i++) begin
      set_id(5'd9, 5'd9, 5'($urandom), ctrl_ID ^ CW'($urandom), $urandom, $urandom);
      tick();
      checks++;
      if (dut_st() !== saved) begin
        errors++; $display("FAIL prio_hold_%0d got %h exp %h", i, dut_st(), saved);
      end
    end
    hold = 0;
    tick();
    checks++;
    if (valid_EX !== 1'b1 || Rs_EX !== 5'd9 || dut_st() !== exp_st) begin
      errors++; $display("FAIL prio_after_hold got v=%b Rs=%0d exp v=1 Rs=9", valid_EX, Rs_EX);
    end
    $display("priority: flush wins, hold keeps state");
  endtask

  task automatic test_async_reset();
    clear_in();
    set_id(5'd1, 5'd2, 5'd3, C_ADD, 32'h11, 32'h22);
    tick();
    #3;
    rst_n = 1'b0;
    exp_st = '0;
    #1;
    checks++;
    if (dut_st() !== exp_st || stall_ID !== 1'b0) begin
      errors++; $display("FAIL async_reset got %h stall=%b exp 0", dut_st(), stall_ID);
    end
    #2;
    rst_n = 1'b1;
    set_id(5'd6, 5'd7, 5'd8, C_ADD, 32'h55, 32'h66);
    tick();
    checks++;
    if (valid_EX !== 1'b1 || busA_EX !== 32'h55 || dut_st() !== exp_st) begin
      errors++; $display("FAIL async_release got v=%b A=%h exp v=1 A=55", valid_EX, busA_EX);
    end
    $display("async_reset: cleared between edges, reloaded after release");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             CW'($urandom), $urandom, $urandom);
      hold     = ($urandom_range(0, 5) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      RegWr_Wr = ($urandom_range(0, 1) == 1);
      Rw_Wr    = 5'($urandom_range(0, 7));
      busW     = $urandom;
      #1;
      checks++;
      if (stall_ID !== model_stall()) begin
        errors++; $display("FAIL rand_stall_%0d got %b exp %b", i, stall_ID, model_stall());
      end
      tick();
      checks++;
      if (dut_st() !== exp_st) begin
        errors++; $display("FAIL rand_state_%0d got %h exp %h", i, dut_st(), exp_st);
      end
    end
    clear_in();
    $display("random: 400 cycles compared");
  endtask

  initial begin
    test_reset();
    test_plain_load();
    test_load_use();
    test_no_false_stall();
    test_bypass();
    test_priority();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Pipeline register between the Reg/Dec (ID) stage and the Exe (EX) stage of the five-stage MIPS pipeline. On each clock edge it captures the decoded instruction: register-file operands, immediate, shamt, func/OP, register addresses, PC, and the 21-bit control bundle. It also performs four jobs on the way through:
- resolves the destination register Rw;
- forwards a same-cycle Wr-stage write into the captured operands;
- detects load-use hazards and inserts a one-cycle bubble;
- squashes the instruction on a taken branch or jump.

## Interface
Parameters:
- `CTRL_W`, default 21: control bundle width. Bit map: [0] Branch, [1] Jump, [2] RegDst, [3] ALUSrc, [8:4] ALUCtr, [9] MemToReg, [10] RegWr, [11] MemWr, [13:12] ExtOp, [14] Rtype, [15] Jal, [16] Rtype_J, [17] Rtype_L, [18] WrByte, [20:19] LoadByte.

Ports:
- `clk`  in  1  — pipeline clock; all state updates on its rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `hold`  in  1  — global freeze (memory wait); register keeps its contents.
- `flush`  in  1  — taken branch or jump resolved downstream; squash the ID instruction.
- `busA_ID`, `busB_ID`  in  32  — Reg[Rs], Reg[Rt] from the register file.
- `PC_Addr_ID`  in  32  — PC of the ID instruction.
- `imm16_ID`  in  16  — immediate field.
- `shamt_ID`  in  5  — shift amount.
- `func_ID`, `OP_ID`  in  6  — func and OP fields.
- `Rs_ID`, `Rt_ID`, `Rd_ID`  in  5  — register addresses.
- `ctrl_ID`  in  CTRL_W  — control bundle from the control unit.
- `busW`  in  32  — Wr-stage write data.
- `Rw_Wr`  in  5  — Wr-stage destination register.
- `RegWr_Wr`  in  1  — Wr-stage write enable, already qualified with ~OverFlow.
- `busA_EX`, `busB_EX`, `PC_Addr_EX`, `imm16_EX`, `shamt_EX`, `func_EX`, `OP_EX`, `Rs_EX`, `Rt_EX`, `Rd_EX`, `ctrl_EX`  out  (same widths as the ID inputs)  — registered copies.
- `Rw_EX`  out  5  — resolved destination register.
- `valid_EX`  out  1  — EX slot holds a real instruction (0 = bubble).
- `stall_ID`  out  1  — combinational; freezes the PC and the IF/ID register this cycle.

## Operation
- **Write-through bypass**
  - Forward A when RegWr_Wr=1, Rw_Wr≠0 and Rw_Wr==Rs_ID: busW replaces busA_ID on capture.
  - Forward B likewise, comparing Rw_Wr with Rt_ID, replacing busB_ID.
  - Jal write-back (Rw=31) is covered because Rw_Wr already carries 31.
- **Rw resolution** (registered, computed from ID fields):
  - ctrl_ID[15] (Jal) → 31;
  - else ctrl_ID[2] (RegDst) → Rd_ID;
  - else Rt_ID.
- **Hazard**
  - hazard = valid_EX & ctrl_EX[9] & ctrl_EX[10] & (Rt_EX≠0) & (Rt_EX==Rs_ID | Rt_EX==Rt_ID).
  - stall_ID = hazard & ~flush.
- **Update priority at each rising edge**, first match wins:
  1. flush → bubble.
  2. hold → keep all state unchanged.
  3. hazard → bubble.
  4. otherwise → load the ID fields (with bypass applied); valid_EX=1.
- **Bubble**: every output register cleared to 0, including ctrl_EX (so RegWr=MemWr=Branch=Jump=0), Rw_EX=0 and valid_EX=0.
- The hazard clears itself: after one bubble valid_EX=0, so stall_ID drops and the held instruction loads on the next edge. The maximum stall is exactly one cycle per load.

## Timing
- **Latency**: 1 cycle. ID values present before edge N appear on the `*_EX` outputs after edge N.
- **stall_ID** is purely combinational from the current EX registers and Rs_ID/Rt_ID; it is valid in the same cycle as the offending ID instruction.
- **Reset**: rst_n=0 forces every output register to 0 immediately, without waiting for clk, including valid_EX=0, ctrl_EX=0 and Rw_EX=0. stall_ID then evaluates to 0.
- **Reset release**: the first rising edge after rst_n=1 performs a normal load.
- **Simultaneous events**
  - flush together with hold → bubble; flush wins.
  - flush together with hazard → bubble, with stall_ID=0, so upstream does not freeze a squashed instruction.
  - hold together with hazard → keep state; stall_ID remains 1.
- **Register 0**: no bypass when Rw_Wr=0, and no hazard when Rt_EX=0.

## Test plan
- **Plain load**: add with Rs=1, Rt=2, Rd=3, ctrl RegDst=1, RegWr=1, busA_ID=0x11, busB_ID=0x22 → after one edge busA_EX=0x11, busB_EX=0x22, Rw_EX=3, valid_EX=1. The same cycle with Jal=1 → Rw_EX=31.
- **Load-use**: lw with Rt=5 in EX (MemToReg=1, RegWr=1) and ID Rs_ID=5 → stall_ID=1 in that cycle. Next edge: valid_EX=0, ctrl_EX=0, and stall_ID falls to 0. Following edge: the ID instruction loads with valid_EX=1.
- **No false stall**:
  - lw with Rt_EX=0 and Rs_ID=0 → stall_ID=0.
  - lw with Rt_EX=5 but valid_EX=0 → stall_ID=0.
- **Bypass**: RegWr_Wr=1, Rw_Wr=1, busW=0xDEADBEEF, Rs_ID=1, Rt_ID=1, busA_ID=busB_ID=0 → busA_EX=busB_EX=0xDEADBEEF. Repeat with Rw_Wr=0 and busW=0xDEADBEEF → busA_EX=busB_EX=0.
- **Priority**:
  - flush=1, hold=1 and hazard present simultaneously → bubble, stall_ID=0.
  - hold=1 alone for 3 cycles → outputs unchanged.
- **Asynchronous reset mid-operation**: with valid_EX=1 and busA_EX=0x11, drive rst_n low between clock edges → all outputs 0 before the next edge. Release rst_n → the first edge loads normally.
